// File: rtl/coax_rx_buffer.sv
// Receive FIFO between the coax bit receiver and the host bus; the host pops via an async read strobe.
// Optional frame-start tagging is built when COAX_RX_BUFFER_SOF_EN is defined.
module coax_rx_buffer #(
    parameter int DATA_WIDTH  = 10,
    parameter int DEPTH       = 16,
    parameter int ALMOST_FULL = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_active,
    input  logic [DATA_WIDTH-1:0]      rx_data,
    input  logic                       rx_data_strobe,
    input  logic                       rx_error,
    input  logic [3:0]                 rx_error_code,
    input  logic                       data_read,
    output logic [DATA_WIDTH-1:0]      data,
    output logic                       data_error,
    output logic                       data_sof,
    output logic                       data_available,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       overflow_clear,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef COAX_RX_BUFFER_SOF_EN
    localparam int EW = DATA_WIDTH + 2;
`else
    localparam int EW = DATA_WIDTH + 1;
`endif

    logic [EW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  rd_s1;
    logic                  rd_s2;
    logic                  rd_prev;
    logic                  pop_req;
    logic                  push_req;
    logic                  do_push;
    logic                  do_pop;
    logic                  full;
    logic                  empty;
    logic                  drop;
    logic [DATA_WIDTH-1:0] payload;
    logic [EW-1:0]         entry;
    logic [EW-1:0]         head;

    always_comb begin
        // An error in the same cycle as a data word takes the slot; the word is lost silently.
        payload  = rx_error ? DATA_WIDTH'(rx_error_code) : rx_data;
        push_req = rx_data_strobe | rx_error;
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        pop_req  = rd_s2 & ~rd_prev;
        do_pop   = pop_req & ~empty;
        do_push  = push_req & (~full | do_pop);
        drop     = push_req & full & ~do_pop;
    end

`ifdef COAX_RX_BUFFER_SOF_EN
    logic first;
    logic active_prev;

    always_ff @(posedge clk) begin
        // Track rx_active during reset so a level held high through reset is not seen as a new frame.
        active_prev <= rx_active;
        if (reset) begin
            first <= 1'b0;
        end else if (rx_active & ~active_prev) begin
            first <= 1'b1;
        end else if (do_push) begin
            first <= 1'b0;
        end
    end

    assign entry    = {rx_error, first, payload};
    assign data_sof = head[DATA_WIDTH];
`else
    logic unused_rx_active;
    assign unused_rx_active = rx_active;
    assign entry    = {rx_error, payload};
    assign data_sof = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_s1    <= 1'b0;
            rd_s2    <= 1'b0;
            rd_prev  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            rd_s1   <= data_read;
            rd_s2   <= rd_s1;
            rd_prev <= rd_s2;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head           <= '0;
            data_available <= 1'b0;
            almost_full    <= 1'b0;
        end else begin
            data_available <= ~empty;
            almost_full    <= (count >= CW'(ALMOST_FULL));
            if (!empty) begin
                head <= mem[rd_ptr];
            end
        end
    end

    assign data       = head[DATA_WIDTH-1:0];
    assign data_error = head[EW-1];

endmodule

// File: tb/tb_coax_rx_buffer.sv
// Directed self-checking bench for coax_rx_buffer (DATA_WIDTH=10, DEPTH=16, ALMOST_FULL=12).
module tb_coax_rx_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_active;
    logic [9:0] rx_data;
    logic       rx_data_strobe;
    logic       rx_error;
    logic [3:0] rx_error_code;
    logic       data_read;
    logic [9:0] data;
    logic       data_error;
    logic       data_sof;
    logic       data_available;
    logic       almost_full;
    logic       overflow;
    logic       overflow_clear;
    logic [4:0] count;

    int vectors = 0;
    int miscompares = 0;

`ifdef COAX_RX_BUFFER_SOF_EN
    localparam logic SOF = 1'b1;
`else
    localparam logic SOF = 1'b0;
`endif

    coax_rx_buffer #(.DATA_WIDTH(10), .DEPTH(16), .ALMOST_FULL(12)) dut (
        .clk(clk), .reset(reset), .rx_active(rx_active), .rx_data(rx_data),
        .rx_data_strobe(rx_data_strobe), .rx_error(rx_error), .rx_error_code(rx_error_code),
        .data_read(data_read), .data(data), .data_error(data_error), .data_sof(data_sof),
        .data_available(data_available), .almost_full(almost_full), .overflow(overflow),
        .overflow_clear(overflow_clear), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [9:0] d);
        rx_data = d;
        rx_data_strobe = 1'b1;
        tick();
        rx_data_strobe = 1'b0;
    endtask

    // Pop lands on the 3rd edge after data_read rises; the new head is visible one edge later.
    task automatic pop();
        data_read = 1'b1;
        repeat (4) tick();
        data_read = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        reset = 1'b1; rx_active = 1'b0; rx_data = '0; rx_data_strobe = 1'b0;
        rx_error = 1'b0; rx_error_code = '0; data_read = 1'b0; overflow_clear = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_count", count, 0);
        check("rst_avail", data_available, 0);
        check("rst_ovf", overflow, 0);
        check("rst_afull", almost_full, 0);
        check("rst_data", data, 0);
        check("rst_err", data_error, 0);
        check("rst_sof", data_sof, 0);

        // Frame of three words
        rx_active = 1'b1;
        tick();
        push(10'h001); push(10'h2AA); push(10'h3FF);
        rx_active = 1'b0;
        check("f_count3", count, 3);
        tick();
        check("f_avail", data_available, 1);
        check("f_data0", data, 10'h001);
        check("f_sof0", data_sof, SOF);
        check("f_err0", data_error, 0);
        pop();
        check("f_data1", data, 10'h2AA);
        check("f_sof1", data_sof, 0);
        check("f_count2", count, 2);
        pop();
        check("f_data2", data, 10'h3FF);
        check("f_sof2", data_sof, 0);
        pop();
        check("f_count0", count, 0);
        check("f_avail0", data_available, 0);

        // Fill to full, almost_full threshold, overflow
        for (int i = 0; i < 11; i++) push(10'h100 + 10'(i));
        tick();
        check("af_11", almost_full, 0);
        check("cnt_11", count, 11);
        push(10'h10B);
        tick();
        check("af_12", almost_full, 1);
        for (int i = 12; i < 16; i++) push(10'h100 + 10'(i));
        check("cnt_16", count, 16);
        check("ovf_pre", overflow, 0);
        push(10'h3EE);
        check("cnt_drop", count, 16);
        check("ovf_set", overflow, 1);
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_clr", overflow, 0);
        check("full_head", data, 10'h100);

        // Push coinciding with a pop while full
        data_read = 1'b1;
        tick(); tick();
        rx_data = 10'h155; rx_data_strobe = 1'b1;
        tick();
        rx_data_strobe = 1'b0;
        check("pp_count", count, 16);
        check("pp_ovf", overflow, 0);
        tick();
        check("pp_head", data, 10'h101);
        data_read = 1'b0;
        repeat (3) tick();
        for (int k = 2; k < 16; k++) begin
            pop();
            check("drain", data, 10'h100 + 10'(k));
        end
        check("drain_cnt2", count, 2);
        pop();
        check("last_155", data, 10'h155);
        check("last_cnt", count, 1);
        pop();
        check("drain_cnt0", count, 0);
        check("drain_avail", data_available, 0);

        // Error and data strobe together; error consumes the frame start
        rx_active = 1'b1;
        tick();
        rx_data = 10'h0F0; rx_data_strobe = 1'b1; rx_error = 1'b1; rx_error_code = 4'h5;
        tick();
        rx_data_strobe = 1'b0; rx_error = 1'b0; rx_error_code = '0;
        check("e_count", count, 1);
        tick();
        check("e_err", data_error, 1);
        check("e_data", data, 10'h005);
        check("e_sof", data_sof, SOF);
        check("e_ovf", overflow, 0);
        push(10'h0AB);
        rx_active = 1'b0;
        check("e_count2", count, 2);
        pop();
        check("e_next", data, 10'h0AB);
        check("e_next_err", data_error, 0);
        check("e_next_sof", data_sof, 0);
        pop();
        check("e_empty", count, 0);

        // Pops on an empty FIFO
        pop(); pop();
        check("u_count", count, 0);
        check("u_avail", data_available, 0);
        check("u_ovf", overflow, 0);

        // Reset with entries queued
        for (int i = 0; i < 5; i++) push(10'h020 + 10'(i));
        tick();
        check("r_count5", count, 5);
        check("r_head", data, 10'h020);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("r_count", count, 0);
        check("r_avail", data_available, 0);
        check("r_data", data, 0);
        check("r_err", data_error, 0);
        check("r_sof", data_sof, 0);
        check("r_afull", almost_full, 0);
        push(10'h2C3);
        tick();
        check("r_push_cnt", count, 1);
        check("r_push_data", data, 10'h2C3);
        check("r_push_avail", data_available, 1);
        check("r_push_sof", data_sof, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
